rgb_color_decoder: RTL

RGB_COLOR_DECODER -- requirements
Module: rgb_color_decoder

---
 rtl/rgb_color_decoder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rgb_color_decoder.sv
// rtl/rgb_color_decoder.sv - RGB LED hue decoder with glitch filter, dwell timer and sequence lock FSM
// Optional dwell tolerance checker is built only when RGB_DWELL_CHECK_EN is defined.
module rgb_color_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_STABLE  = 4,
   parameter int DWELL_BITS  = 24,
   parameter int LOCK_COUNT  = 6
`ifdef RGB_DWELL_CHECK_EN
   ,
   parameter int EXPECTED_DWELL = 2000000,
   parameter int DWELL_TOL      = 1000
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RGB_R,
   input  logic                  RGB_G,
   input  logic                  RGB_B,
   output logic [2:0]            color,
   output logic                  color_valid,
   output logic [DWELL_BITS-1:0] dwell,
   output logic                  dwell_valid,
   output logic                  seq_err,
   output logic                  locked,
   output logic                  dwell_err
);

   localparam int FCW = $clog2(MIN_STABLE + 1);
   localparam int GCW = $clog2(LOCK_COUNT + 1);

   typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED} state_t;

   function automatic logic [2:0] decode_pat(input logic [2:0] p);
      case (p)
         3'b011:  return 3'd0;
         3'b001:  return 3'd1;
         3'b101:  return 3'd2;
         3'b100:  return 3'd3;
         3'b110:  return 3'd4;
         3'b010:  return 3'd5;
         3'b111:  return 3'd6;
         default: return 3'd7;
      endcase
   endfunction

   logic [2:0]            sync_q [SYNC_STAGES];
   logic [2:0]            sync_pat;
   logic [2:0]            cand_q;
   logic [2:0]            acc_pat_q;
   logic [FCW-1:0]        cnt_q;
   logic [FCW-1:0]        run_len;
   logic                  accept_now;
   logic                  acc_evt_q;
   logic [2:0]            hue;
   logic [DWELL_BITS-1:0] seg_cnt_q;
   logic [DWELL_BITS-1:0] dwell_next;
   logic                  first_seg_q;
   state_t                state_q, state_d;
   logic [GCW-1:0]        good_q, good_d, good_inc;
   logic [2:0]            prev_q, prev_d, succ_hue;
   logic                  is_hue, succ_hit, seq_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b111;
      end else begin
         sync_q[0] <= {RGB_R, RGB_B, RGB_G};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_pat   = sync_q[SYNC_STAGES-1];
   // run_len counts the current sample, so a fresh candidate starts at 1
   assign run_len    = (sync_pat == cand_q) ? cnt_q + FCW'(1) : FCW'(1);
   assign accept_now = (sync_pat != acc_pat_q) && (run_len >= FCW'(MIN_STABLE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_pat_q <= 3'b111;
         cand_q    <= 3'b111;
         cnt_q     <= '0;
         acc_evt_q <= 1'b0;
      end else begin
         acc_evt_q <= accept_now;
         cand_q    <= sync_pat;
         if (sync_pat == acc_pat_q) begin
            cnt_q <= '0;
         end else if (accept_now) begin
            acc_pat_q <= sync_pat;
            cnt_q     <= '0;
         end else begin
            cnt_q <= run_len;
         end
      end
   end

   assign hue        = decode_pat(acc_pat_q);
   assign dwell_next = (seg_cnt_q == '1) ? seg_cnt_q : seg_cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_cnt_q   <= '0;
         first_seg_q <= 1'b1;
         color       <= 3'd6;
         color_valid <= 1'b0;
         dwell       <= '0;
         dwell_valid <= 1'b0;
      end else begin
         dwell_valid <= 1'b0;
         if (acc_evt_q) begin
            seg_cnt_q   <= '0;
            first_seg_q <= 1'b0;
            color       <= hue;
            color_valid <= (hue < 3'd6);
            // the segment that began at reset has no meaningful length
            if (!first_seg_q) begin
               dwell       <= dwell_next;
               dwell_valid <= 1'b1;
            end
         end else if (seg_cnt_q != '1) begin
            seg_cnt_q <= seg_cnt_q + 1'b1;
         end
      end
   end

`ifdef RGB_DWELL_CHECK_EN
   localparam logic [63:0] EXP64 = 64'(EXPECTED_DWELL);
   localparam logic [63:0] TOL64 = 64'(DWELL_TOL);
   logic [63:0] dn64;
   logic        tol_viol;

   always_comb begin
      dn64     = 64'(dwell_next);
      tol_viol = (dwell_next == '1) || (dn64 > EXP64 + TOL64) || (dn64 + TOL64 < EXP64);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dwell_err <= 1'b0;
      else        dwell_err <= acc_evt_q && !first_seg_q && tol_viol;
   end
`else
   assign dwell_err = 1'b0;
`endif

   assign is_hue   = (hue < 3'd6);
   assign succ_hue = (prev_q == 3'd5) ? 3'd0 : prev_q + 3'd1;
   assign succ_hit = (hue == succ_hue);
   assign good_inc = good_q + GCW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         good_q  <= '0;
         prev_q  <= '0;
         seq_err <= 1'b0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         prev_q  <= prev_d;
         seq_err <= seq_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      prev_d  = prev_q;
      if (acc_evt_q) begin
         if (!is_hue) begin
            state_d = S_IDLE;
            good_d  = '0;
         end else begin
            prev_d = hue;
            case (state_q)
               S_IDLE: begin
                  state_d = S_TRACK;
                  good_d  = '0;
               end
               S_TRACK: begin
                  if (succ_hit) begin
                     good_d = good_inc;
                     if (good_inc >= GCW'(LOCK_COUNT)) state_d = S_LOCKED;
                  end else begin
                     good_d = '0;
                  end
               end
               S_LOCKED: begin
                  if (!succ_hit) begin
                     state_d = S_TRACK;
                     good_d  = '0;
                  end
               end
               default: begin
                  state_d = S_IDLE;
                  good_d  = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      seq_err_d = 1'b0;
      locked    = (state_q == S_LOCKED);
      if (acc_evt_q) begin
         if (!is_hue) seq_err_d = (state_q == S_LOCKED);
         else         seq_err_d = (state_q != S_IDLE) && !succ_hit;
      end
   end

endmodule
